// File: rtl/control_fsm_if.sv
// control_fsm_if: unified memory port of the multicycle control unit.
// Ports: req/we driven by control_fsm (master), ready returned by memory (slave).
interface control_fsm_if;
  logic req;
  logic we;
  logic ready;

  modport master (
    output req,
    output we,
    input  ready
  );

  modport slave (
    input  req,
    input  we,
    output ready
  );
endinterface

// File: rtl/control_fsm.sv
// control_fsm: multicycle RV32I control unit (FETCH/DECODE/EXEC/MEM/WB/TRAP).
// Ports: clk, rst, instr, zero/lt/ltu in; mem (req/we/ready); datapath strobes,
// mux selects, state, illegal, retired, instret out.
// Option: MEM_HANDSHAKE_EN makes FETCH/MEM wait for mem.ready.
module control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             lt,
  input  logic             ltu,
  control_fsm_if.master    mem,
  output logic             pc_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_ctrl,
  output logic [2:0]       imm_src,
  output logic [1:0]       result_src,
  output logic             pc_src,
  output logic [2:0]       state,
  output logic             illegal,
  output logic             retired,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  state_t st;

  logic rdy;
`ifdef MEM_HANDSHAKE_EN
  assign rdy = mem.ready;
`else
  // memory is treated as zero-wait; ready is ignored
  assign rdy = 1'b1 | mem.ready;
`endif

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       f7b5;
  logic       unused_bits;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign f7b5   = instr[30];
  assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};

  logic is_op, is_opi, is_lui, is_auipc;
  logic is_load, is_store, is_br, is_jal, is_jalr;
  logic br_bad, valid, taken, ret;

  assign is_op    = opcode == 7'b0110011;
  assign is_opi   = opcode == 7'b0010011;
  assign is_lui   = opcode == 7'b0110111;
  assign is_auipc = opcode == 7'b0010111;
  assign is_load  = opcode == 7'b0000011;
  assign is_store = opcode == 7'b0100011;
  assign is_br    = opcode == 7'b1100011;
  assign is_jal   = opcode == 7'b1101111;
  assign is_jalr  = opcode == 7'b1100111;

  // funct3 010/011 have no branch meaning
  assign br_bad = is_br && (funct3[2:1] == 2'b01);
  assign valid  = ~br_bad & (is_op | is_opi | is_lui | is_auipc |
                  is_load | is_store | is_br | is_jal | is_jalr);

  always_comb begin
    taken = 1'b0;
    unique case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = ~zero;
      3'b100:  taken = lt;
      3'b101:  taken = ~lt;
      3'b110:  taken = ltu;
      3'b111:  taken = ~ltu;
      default: taken = 1'b0;
    endcase
  end

  function automatic logic [3:0] alu_dec(
    input logic [2:0] f3,
    input logic       f7,
    input logic       reg_op
  );
    logic [3:0] c;
    unique case (f3)
      3'b000:  c = (reg_op && f7) ? 4'd1 : 4'd0;
      3'b001:  c = 4'd7;
      3'b010:  c = 4'd5;
      3'b011:  c = 4'd6;
      3'b100:  c = 4'd4;
      3'b101:  c = f7 ? 4'd9 : 4'd8;
      3'b110:  c = 4'd3;
      default: c = 4'd2;
    endcase
    return c;
  endfunction

  always_comb begin
    mem.req    = 1'b0;
    mem.we     = 1'b0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'd0;
    alu_src_b  = 2'd0;
    alu_ctrl   = 4'd0;
    imm_src    = 3'd0;
    result_src = 2'd0;
    pc_src     = 1'b0;
    ret        = 1'b0;
    unique case (st)
      S_FETCH: begin
        mem.req = 1'b1;
        if (rdy) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_src_a = 2'd2;
          alu_src_b = 2'd2;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'd1;
        imm_src   = is_br ? 3'd2 : 3'd4;
      end
      S_EXEC: begin
        unique case (1'b1)
          is_op: begin
            alu_src_a = 2'd1;
            alu_ctrl  = alu_dec(funct3, f7b5, 1'b1);
          end
          is_opi: begin
            alu_src_a = 2'd1;
            alu_src_b = 2'd1;
            alu_ctrl  = alu_dec(funct3, f7b5, 1'b0);
          end
          is_lui: begin
            alu_src_a = 2'd3;
            alu_src_b = 2'd1;
            imm_src   = 3'd3;
          end
          is_auipc: begin
            alu_src_b = 2'd1;
            imm_src   = 3'd3;
          end
          is_load, is_store: begin
            alu_src_a = 2'd1;
            alu_src_b = 2'd1;
            imm_src   = is_store ? 3'd1 : 3'd0;
          end
          is_br: begin
            alu_src_a = 2'd1;
            alu_ctrl  = 4'd1;
            pc_write  = taken;
            pc_src    = taken;
            ret       = 1'b1;
          end
          is_jal: begin
            pc_write   = 1'b1;
            pc_src     = 1'b1;
            reg_write  = 1'b1;
            result_src = 2'd3;
            ret        = 1'b1;
          end
          is_jalr: begin
            alu_src_a  = 2'd1;
            alu_src_b  = 2'd1;
            pc_write   = 1'b1;
            reg_write  = 1'b1;
            result_src = 2'd3;
            ret        = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        mem.req = 1'b1;
        mem.we  = is_store;
        ret     = rdy & is_store;
      end
      S_WB: begin
        reg_write  = 1'b1;
        result_src = is_load ? 2'd1 : 2'd0;
        ret        = 1'b1;
      end
      default: ;
    endcase
    // reset cycle: nothing may write or retire
    if (rst) begin
      mem.req   = 1'b0;
      mem.we    = 1'b0;
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      ret       = 1'b0;
    end
  end

  assign retired = ret;
  assign state   = st;
  assign illegal = st == S_TRAP;

  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= S_FETCH;
      instret <= '0;
    end else begin
      if (ret) instret <= instret + CNT_W'(1);
      unique case (st)
        S_FETCH:  if (rdy) st <= S_DECODE;
        S_DECODE: st <= valid ? S_EXEC : S_TRAP;
        S_EXEC: begin
          unique case (1'b1)
            is_load | is_store: st <= S_MEM;
            is_op | is_opi | is_lui | is_auipc: st <= S_WB;
            default: st <= S_FETCH;
          endcase
        end
        S_MEM:    if (rdy) st <= is_store ? S_FETCH : S_WB;
        S_WB:     st <= S_FETCH;
        S_TRAP:   st <= S_TRAP;
        default:  st <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: directed plus random instruction stream against a
// per-instruction phase model of the control unit.
module tb_control_fsm;
  localparam int W = 4;
  localparam int C_OP = 0, C_OPI = 1, C_LUI = 2, C_AUIPC = 3, C_LD = 4;
  localparam int C_ST = 5, C_BR = 6, C_JAL = 7, C_JALR = 8, C_ILL = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] instr = '0;
  logic zero = 1'b0, lt = 1'b0, ltu = 1'b0;
  logic pc_write, ir_write, reg_write, pc_src, illegal, retired;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [3:0] alu_ctrl;
  logic [2:0] imm_src, state;
  logic [W-1:0] instret;

  control_fsm_if mem();

  control_fsm #(.CNT_W(W)) dut (
    .clk(clk), .rst(rst), .instr(instr),
    .zero(zero), .lt(lt), .ltu(ltu), .mem(mem),
    .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
    .imm_src(imm_src), .result_src(result_src), .pc_src(pc_src),
    .state(state), .illegal(illegal), .retired(retired), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] st;
    logic mreq, mwe, pcw, irw, rw, ret, pcs, ill;
    logic [1:0] a, b, rs;
    logic [3:0] ctl;
    logic [2:0] imm;
  } exp_t;

  int total = 0;
  int bad = 0;
  logic [W-1:0] ecnt = '0;
  logic fix_rdy = 1'b0;
  int stall = -1;
  logic use_fl = 1'b0;
  logic [2:0] fl = '0;
  int hold = 3;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic eff(input logic r);
`ifdef MEM_HANDSHAKE_EN
    return r;
`else
    return r | 1'b1;
`endif
  endfunction

  function automatic logic taken(input logic [2:0] f3, input logic z,
                                 input logic l, input logic u);
    case (f3)
      3'd0: return z;
      3'd1: return !z;
      3'd4: return l;
      3'd5: return !l;
      3'd6: return u;
      3'd7: return !u;
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive(input int waits, output logic go);
    logic r;
    r = 1'($urandom_range(0, 1));
    if (fix_rdy || waits >= 3) r = 1'b1;
    if (stall >= 0) r = (waits >= stall);
    mem.ready = r;
    go = eff(r);
    if (use_fl) {zero, lt, ltu} = fl;
    else {zero, lt, ltu} = 3'($urandom_range(0, 7));
  endtask

  task automatic check(input exp_t e, input string ph);
    chk({ph, ".state"}, state, e.st);
    chk({ph, ".mem_req"}, mem.req, e.mreq);
    chk({ph, ".mem_we"}, mem.we, e.mwe);
    chk({ph, ".pc_write"}, pc_write, e.pcw);
    chk({ph, ".ir_write"}, ir_write, e.irw);
    chk({ph, ".reg_write"}, reg_write, e.rw);
    chk({ph, ".retired"}, retired, e.ret);
    chk({ph, ".pc_src"}, pc_src, e.pcs);
    chk({ph, ".illegal"}, illegal, e.ill);
    chk({ph, ".alu_src_a"}, alu_src_a, e.a);
    chk({ph, ".alu_src_b"}, alu_src_b, e.b);
    chk({ph, ".result_src"}, result_src, e.rs);
    chk({ph, ".alu_ctrl"}, alu_ctrl, e.ctl);
    chk({ph, ".imm_src"}, imm_src, e.imm);
    chk({ph, ".instret"}, instret, ecnt);
  endtask

  task automatic check_rst(input string ph);
    chk({ph, ".mem_req"}, mem.req, 0);
    chk({ph, ".mem_we"}, mem.we, 0);
    chk({ph, ".pc_write"}, pc_write, 0);
    chk({ph, ".ir_write"}, ir_write, 0);
    chk({ph, ".reg_write"}, reg_write, 0);
    chk({ph, ".retired"}, retired, 0);
  endtask

  task automatic do_reset();
    logic go;
    rst = 1'b1;
    drive(0, go);
    #3 check_rst("rst");
    step();
    rst = 1'b0;
    ecnt = '0;
    chk("post_rst.state", state, 0);
    chk("post_rst.illegal", illegal, 0);
    chk("post_rst.instret", instret, 0);
  endtask

  task automatic gen(input int cls, output logic [31:0] ins,
                     output logic [3:0] ectl);
    logic [2:0] f3tab [10];
    logic [6:0] badop [4];
    int m;
    f3tab = '{3'd0, 3'd0, 3'd7, 3'd6, 3'd4, 3'd2, 3'd3, 3'd1, 3'd5, 3'd5};
    badop = '{7'h00, 7'h7f, 7'h0f, 7'h73};
    ins = $urandom;
    ectl = '0;
    case (cls)
      C_OP, C_OPI: begin
        m = $urandom_range(0, 9);
        if (cls == C_OPI && m == 1) m = 0;
        ins[14:12] = f3tab[m];
        ins[6:0] = (cls == C_OP) ? 7'b0110011 : 7'b0010011;
        if (m == 1 || m == 9) ins[30] = 1'b1;
        else if (cls == C_OP || m == 8) ins[30] = 1'b0;
        ectl = 4'(m);
      end
      C_LUI:   ins[6:0] = 7'b0110111;
      C_AUIPC: ins[6:0] = 7'b0010111;
      C_LD:    ins[6:0] = 7'b0000011;
      C_ST:    ins[6:0] = 7'b0100011;
      C_BR: begin
        ins[6:0] = 7'b1100011;
        m = $urandom_range(0, 5);
        ins[14:12] = (m < 2) ? 3'(m) : 3'(m + 2);
      end
      C_JAL:   ins[6:0] = 7'b1101111;
      C_JALR:  ins[6:0] = 7'b1100111;
      default: begin
        if ($urandom_range(0, 1) == 1) begin
          ins[6:0] = badop[$urandom_range(0, 3)];
        end else begin
          ins[6:0] = 7'b1100011;
          ins[14:12] = {2'b01, 1'($urandom_range(0, 1))};
        end
      end
    endcase
  endtask

  task automatic run_instr(input int cls, input logic [31:0] ins,
                           input logic [3:0] ectl, input logic rst_mem);
    exp_t e;
    logic go;
    int w;
    instr = ins;
    w = 0;
    do begin
      drive(w, go);
      e = '{default: 0};
      e.mreq = 1'b1;
      if (go) begin
        e.irw = 1'b1; e.pcw = 1'b1; e.a = 2'd2; e.b = 2'd2;
      end
      #3 check(e, "fetch");
      step();
      w++;
    end while (!go);

    drive(0, go);
    e = '{default: 0};
    e.st = 3'd1; e.b = 2'd1;
    e.imm = (ins[6:0] == 7'b1100011) ? 3'd2 : 3'd4;
    #3 check(e, "decode");
    step();

    if (cls == C_ILL) begin
      for (int i = 0; i < hold; i++) begin
        drive(0, go);
        e = '{default: 0};
        e.st = 3'd7; e.ill = 1'b1;
        #3 check(e, "trap");
        step();
      end
      do_reset();
      return;
    end

    drive(0, go);
    e = '{default: 0};
    e.st = 3'd2;
    case (cls)
      C_OP:    begin e.a = 2'd1; e.ctl = ectl; end
      C_OPI:   begin e.a = 2'd1; e.b = 2'd1; e.ctl = ectl; end
      C_LUI:   begin e.a = 2'd3; e.b = 2'd1; e.imm = 3'd3; end
      C_AUIPC: begin e.b = 2'd1; e.imm = 3'd3; end
      C_LD:    begin e.a = 2'd1; e.b = 2'd1; end
      C_ST:    begin e.a = 2'd1; e.b = 2'd1; e.imm = 3'd1; end
      C_BR: begin
        e.a = 2'd1; e.ctl = 4'd1; e.ret = 1'b1;
        e.pcw = taken(ins[14:12], zero, lt, ltu);
        e.pcs = e.pcw;
      end
      C_JAL: begin
        e.pcw = 1'b1; e.pcs = 1'b1; e.rw = 1'b1; e.rs = 2'd3; e.ret = 1'b1;
      end
      default: begin
        e.a = 2'd1; e.b = 2'd1; e.pcw = 1'b1;
        e.rw = 1'b1; e.rs = 2'd3; e.ret = 1'b1;
      end
    endcase
    #3 check(e, "exec");
    step();
    if (e.ret) begin
      ecnt = ecnt + 1'b1;
      return;
    end

    if (cls == C_LD || cls == C_ST) begin
      w = 0;
      do begin
        drive(w, go);
        if (rst_mem) begin
          rst = 1'b1;
          #3 check_rst("rst_mem");
          step();
          rst = 1'b0;
          ecnt = '0;
          chk("rst_mem.state", state, 0);
          chk("rst_mem.instret", instret, 0);
          return;
        end
        e = '{default: 0};
        e.st = 3'd3; e.mreq = 1'b1; e.mwe = (cls == C_ST);
        e.ret = go && (cls == C_ST);
        #3 check(e, "mem");
        step();
        if (e.ret) ecnt = ecnt + 1'b1;
        w++;
      end while (!go);
      if (cls == C_ST) return;
    end

    drive(0, go);
    e = '{default: 0};
    e.st = 3'd4; e.rw = 1'b1; e.ret = 1'b1;
    e.rs = (cls == C_LD) ? 2'd1 : 2'd0;
    #3 check(e, "wb");
    step();
    ecnt = ecnt + 1'b1;
  endtask

  initial begin
    logic [31:0] ins;
    logic [3:0] ectl;
    int cls;
    mem.ready = 1'b1;
    rst = 1'b1;
    step();
    #3 check_rst("rst0");
    step();
    chk("rst1.state", state, 0);
    chk("rst1.illegal", illegal, 0);
    chk("rst1.instret", instret, 0);
    rst = 1'b0;

    fix_rdy = 1'b1;
    run_instr(C_ST, 32'h00112023, 4'd0, 1'b1);
    run_instr(C_OPI, 32'h00500093, 4'd0, 1'b0);
    chk("addi.instret", instret, 1);

    use_fl = 1'b1;
    fl = 3'b100;
    run_instr(C_BR, 32'h00208463, 4'd0, 1'b0);
    fl = 3'b000;
    run_instr(C_BR, 32'h00208463, 4'd0, 1'b0);
    fl = 3'b010;
    run_instr(C_BR, 32'h0020c463, 4'd0, 1'b0);
    use_fl = 1'b0;

    run_instr(C_LD, 32'h0000a083, 4'd0, 1'b0);
    run_instr(C_ST, 32'h00112023, 4'd0, 1'b0);
    chk("lwsw.instret", instret, 6);

    stall = 3;
    run_instr(C_OPI, 32'h00500093, 4'd0, 1'b0);
    stall = -1;

    hold = 10;
    run_instr(C_ILL, 32'h00000000, 4'd0, 1'b0);
    hold = 3;

    for (int i = 0; i < 15; i++)
      run_instr(C_OPI, 32'h00500093, 4'd0, 1'b0);
    chk("wrap.pre", instret, 15);
    run_instr(C_OPI, 32'h00500093, 4'd0, 1'b0);
    chk("wrap.post", instret, 0);

    fix_rdy = 1'b0;
    for (int i = 0; i < 150; i++) begin
      cls = $urandom_range(0, 9);
      gen(cls, ins, ectl);
      run_instr(cls, ins, ectl, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
